lc3_fetch_queue: RTL

LC-3 fetch stage with a decoupling instruction queue. It consumes the controller's fetch controls (`br_taken`, `taddr`, `enable_updatePC`, `enable_fetch`) and owns the PC. It issues reads to a 1-cycle-latency instruction memory and buffers the returned words with their PC/NPC. Decode drains the queue through a valid/ready handshake, and taken branches flush the queue and any read still in flight.

---
 rtl/lc3_fetch_pkg.sv | 13 +
 rtl/lc3_fetch_queue_fifo.sv | 61 ++++++
 rtl/lc3_fetch_queue.sv | 92 +++++++++
 3 files changed

// File: rtl/lc3_fetch_pkg.sv
// LC-3 fetch queue shared types.
// Reset PC constant and the buffered fetch entry.
package lc3_fetch_pkg;

  localparam logic [15:0] LC3_RESET_PC = 16'h3000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/lc3_fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries.
// Flush empties it in one cycle; pointers wrap naturally.
module fetch_fifo
  import lc3_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // pointer and count update; flush wins over push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage; cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/lc3_fetch_queue.sv
// LC-3 fetch stage: owns the PC, issues reads,
// buffers responses and flushes on taken branches.
module lc3_fetch_queue
  import lc3_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = LC3_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   br_taken,
  input  logic [15:0]            taddr,
  input  logic                   enable_updatePC,
  input  logic                   enable_fetch,
  output logic                   instrmem_rd,
  output logic [15:0]            pc,
  input  logic [15:0]            dout,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [15:0]            inst_pc,
  output logic [15:0]            inst_npc,
  output logic [15:0]            instr,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

  logic         redirect;
  logic         issue;
  logic         push;
  logic         pop;
  logic         inflight;
  logic         empty;
  logic         full;
  logic [15:0]  tag;
  logic [AW+1:0] credit;
  fetch_entry_t din;
  fetch_entry_t head;

  assign redirect = br_taken & enable_updatePC;
  assign credit   = {1'b0, occupancy}
                  + {{(AW+1){1'b0}}, inflight};
  assign issue    = reset & enable_fetch
                  & enable_updatePC & ~redirect
                  & (credit < LIMIT);

  assign instrmem_rd = issue;
  assign inst_valid  = ~empty & ~redirect;
  assign pop         = inst_valid & inst_ready;
  assign push        = inflight & ~redirect & ~full;

  assign din = '{pc: tag, npc: tag + 16'd1, instr: dout};

  assign inst_pc  = head.pc;
  assign inst_npc = head.npc;
  assign instr    = head.instr;

  // PC, in-flight flag and issued-PC tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      tag      <= '0;
    end else if (redirect) begin
      pc       <= taddr;
      inflight <= 1'b0;
    end else if (issue) begin
      pc       <= pc + 16'd1;
      inflight <= 1'b1;
      tag      <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .head  (head),
    .count (occupancy),
    .empty (empty),
    .full  (full)
  );

endmodule
